wb_store_buffer: RTL and testbench
==================================

Name: wb_store_buffer

Overview:
- Parametrised successor to the writeback-stage D-cache write path. Writeback no longer stalls on every store while the D-cache is busy.
- Committed stores from writeback enter a DEPTH-entry in-order FIFO. The FIFO drains to the D-cache write port through a valid/ready handshake.
- Writeback stalls only when the buffer is full and no entry leaves that cycle.
- Sits between the writeback stage and the D-cache. Also reports drain status to the halt logic.

Parameters:
- DEPTH, 4: number of buffered stores. Power of two, 2..16.
- AW, 32: address width.
- DW, 64: data width. Holds GPR data zero-extended, or MM data.
- PW, 2: pointer width. Equals log2(DEPTH).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  asynchronous, active-high reset.
- WB_sb_enq_v  in  1  valid committed store presented by writeback this cycle.
- WB_sb_addr  in  AW  store byte address.
- WB_sb_data  in  DW  store data.
- WB_sb_size  in  2  size code: 00 byte, 01 word, 10 dword, 11 qword (MM).
- WB_sb_stall  out  1  writeback must hold its store; enqueue is refused this cycle.
- Dcache_Write  out  1  head entry valid; a write is requested.
- Dcache_Address  out  AW  head entry address.
- Dcache_Data  out  DW  head entry data.
- Dcache_Size  out  2  head entry size code.
- In_write_ready  in  1  D-cache accepts the head write this cycle.
- sb_count  out  PW+1  number of occupied entries.
- sb_empty  out  1  buffer empty; halt may complete.
- sb_full  out  1  count equals DEPTH.
- ld_addr  in  AW  load address probed by execute (forwarding only).
- ld_fwd_hit  out  1  load fully satisfied from the buffer (forwarding only).
- ld_fwd_data  out  DW  forwarded data (forwarding only).
- ld_conflict  out  1  load overlaps a buffered store it cannot forward from; execute must stall (forwarding only).

Behaviour:
- Storage: circular array of DEPTH entries {addr, data, size}, plus a per-entry valid bit, head pointer, tail pointer and count.
- Pointers are PW bits wide and wrap from DEPTH-1 to 0. Count is PW+1 bits, range 0..DEPTH.
- deq = Dcache_Write & In_write_ready.
- enq = WB_sb_enq_v & ~WB_sb_stall.
- WB_sb_stall = WB_sb_enq_v & sb_full & ~deq. When full, a same-cycle dequeue frees a slot, so the enqueue is accepted and count stays DEPTH.
- Enqueue writes the entry at the tail and advances the tail. Dequeue clears the head valid bit and advances the head.
- Simultaneous enq and deq: count unchanged, both pointers advance.
- Enq only: count increments. Deq only: count decrements.
- Latency: a store enqueued at edge N is on the Dcache_* outputs from cycle N+1 at the earliest. There is no combinational bypass from WB_sb_* to Dcache_*.
- Dcache_Write = sb_empty inverted. Dcache_Address, Dcache_Data and Dcache_Size come directly from the head entry.
- Dcache_* outputs stay stable while In_write_ready is low. Each entry is presented until it is accepted; there are no drops and no reordering.
- Empty: Dcache_Write = 0, and a deq cannot occur.
- sb_empty = (count == 0). sb_full = (count == DEPTH). Both are derived from the registered count, not from in-flight handshakes.
- Reset (CLR high, any time, including mid-drain): count = 0, head = 0, tail = 0, all valid bits = 0.
- Reset output values: Dcache_Write = 0, WB_sb_stall = 0, sb_empty = 1, sb_full = 0, sb_count = 0, ld_fwd_hit = 0, ld_conflict = 0.
- Reset discards buffered stores; this is intended on machine reset only.
- Data in a non-valid entry is don't-care but must never reach Dcache_Write = 1.

Optional Feature:
- Macro: WB_SB_FORWARD_EN.
- Defined: combinational store-to-load probe over all valid entries.
- Overlap: an entry overlaps ld_addr when addr[AW-1:3] matches ld_addr[AW-1:3].
- The youngest overlapping entry is the one nearest the tail.
- ld_fwd_hit = 1 and ld_fwd_data = that entry's data when the youngest overlap has size 11 and addr[2:0] = 000 = ld_addr[2:0].
- Any other overlap gives ld_conflict = 1 and ld_fwd_hit = 0.
- No overlap gives both outputs 0 and ld_fwd_data = 0.
- Undefined: ld_fwd_hit, ld_conflict and ld_fwd_data are tied to 0, ld_addr is ignored, and no comparators are built.

Test Plan:
- Reset, then enqueue addr 0x1000, data 0xAA, size 10 with In_write_ready = 1 → next cycle Dcache_Write = 1, Dcache_Address = 0x1000, Dcache_Data = 0xAA; one cycle later sb_empty = 1.
- In_write_ready = 0, enqueue 4 stores (DEPTH = 4) → sb_full = 1 and sb_count = 4. A 5th enqueue with ready = 0 gives WB_sb_stall = 1. With ready = 1 in the same cycle: stall = 0, count stays 4, first store dequeued.
- Fill then drain 6 stores across a pointer wrap, toggling ready every other cycle → D-cache sees addresses in exact enqueue order with no duplicates; sb_count returns to 0.
- Three entries buffered, CLR pulsed asynchronously mid-cycle → Dcache_Write = 0, sb_count = 0, sb_empty = 1 before the next edge; later enqueues start at slot 0.
- WB_SB_FORWARD_EN: buffer qword 0x2000 = 0x1111, then qword 0x2000 = 0x2222, probe ld_addr 0x2000 → ld_fwd_hit = 1, ld_fwd_data = 0x2222. Probe 0x2004 → ld_conflict = 1. Probe 0x3000 → both 0.
- Simultaneous enq and deq at count = 2 for 5 cycles → sb_count stays 2; output order is preserved.

Source files
------------

// File: rtl/wb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : wb_store_buffer
// Description : In-order store buffer between writeback and the D-cache write
//               port. Committed stores are queued in a DEPTH-entry circular
//               FIFO and drained through a valid/ready handshake. Writeback
//               stalls only when the buffer is full and nothing leaves.
//               Define WB_SB_FORWARD_EN to build the store-to-load probe
//               (ld_fwd_hit / ld_fwd_data / ld_conflict); otherwise those
//               outputs are tied to zero and ld_addr is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 64,
    parameter int PW    = 2
) (
    input  logic          CLK,
    input  logic          CLR,
    // writeback side
    input  logic          WB_sb_enq_v,
    input  logic [AW-1:0] WB_sb_addr,
    input  logic [DW-1:0] WB_sb_data,
    input  logic [1:0]    WB_sb_size,
    output logic          WB_sb_stall,
    // D-cache write port
    output logic          Dcache_Write,
    output logic [AW-1:0] Dcache_Address,
    output logic [DW-1:0] Dcache_Data,
    output logic [1:0]    Dcache_Size,
    input  logic          In_write_ready,
    // status
    output logic [PW:0]   sb_count,
    output logic          sb_empty,
    output logic          sb_full,
    // load probe
    input  logic [AW-1:0] ld_addr,
    output logic          ld_fwd_hit,
    output logic [DW-1:0] ld_fwd_data,
    output logic          ld_conflict
);

    localparam logic [PW:0]   c_DEPTH   = (PW+1)'(DEPTH);
    localparam logic [PW:0]   c_CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] c_PTR_ONE = PW'(1);

    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [1:0]       r_size [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW:0]      r_count;

    logic w_enq;
    logic w_deq;

    // Status comes from the registered count only, never from the handshake.
    assign sb_count = r_count;
    assign sb_empty = (r_count == '0);
    assign sb_full  = (r_count == c_DEPTH);

    // Head entry is presented directly; it holds until accepted.
    assign Dcache_Write   = ~sb_empty;
    assign Dcache_Address = r_addr[r_head];
    assign Dcache_Data    = r_data[r_head];
    assign Dcache_Size    = r_size[r_head];

    // A same-cycle dequeue frees the slot a full-buffer enqueue needs.
    assign w_deq       = Dcache_Write & In_write_ready;
    assign WB_sb_stall = WB_sb_enq_v & sb_full & ~w_deq;
    assign w_enq       = WB_sb_enq_v & ~WB_sb_stall;

    // Entry payload write at the tail; contents of free slots are don't-care.
    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_addr[r_tail] <= WB_sb_addr;
            r_data[r_tail] <= WB_sb_data;
            r_size[r_tail] <= WB_sb_size;
        end
    end

    // Pointer, valid-bit and occupancy bookkeeping.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            // Clear before set: when full, head and tail name the same slot
            // and a simultaneous enqueue must leave it valid.
            if (w_deq) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_PTR_ONE;
            end
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + c_PTR_ONE;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef WB_SB_FORWARD_EN
    logic          w_found;
    logic [PW-1:0] w_sel;
    logic [PW-1:0] w_idx;

    // Walk from oldest to youngest so the last overlap seen is the youngest.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (r_valid[w_idx] && (r_addr[w_idx][AW-1:3] == ld_addr[AW-1:3])) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // Only an aligned qword store covers every byte a load may need.
    always_comb begin
        ld_fwd_hit  = w_found && (r_size[w_sel] == 2'b11) &&
                      (r_addr[w_sel][2:0] == 3'b000) && (ld_addr[2:0] == 3'b000);
        ld_conflict = w_found && !ld_fwd_hit;
        ld_fwd_data = ld_fwd_hit ? r_data[w_sel] : '0;
    end
`else
    logic w_unused_probe;

    // Probe disabled: outputs tied off, probe address and valid bits unused.
    assign w_unused_probe = ^{ld_addr, r_valid};
    assign ld_fwd_hit     = 1'b0;
    assign ld_conflict    = 1'b0;
    assign ld_fwd_data    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_store_buffer
// Description : Directed, table-driven bench for wb_store_buffer (DEPTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_store_buffer;

    logic        CLK;
    logic        CLR;
    logic        WB_sb_enq_v;
    logic [31:0] WB_sb_addr;
    logic [63:0] WB_sb_data;
    logic [1:0]  WB_sb_size;
    logic        WB_sb_stall;
    logic        Dcache_Write;
    logic [31:0] Dcache_Address;
    logic [63:0] Dcache_Data;
    logic [1:0]  Dcache_Size;
    logic        In_write_ready;
    logic [2:0]  sb_count;
    logic        sb_empty;
    logic        sb_full;
    logic [31:0] ld_addr;
    logic        ld_fwd_hit;
    logic [63:0] ld_fwd_data;
    logic        ld_conflict;

    int n_checks = 0;
    int n_fail   = 0;

    wb_store_buffer #(.DEPTH(4), .AW(32), .DW(64), .PW(2)) dut (
        .CLK            (CLK),
        .CLR            (CLR),
        .WB_sb_enq_v    (WB_sb_enq_v),
        .WB_sb_addr     (WB_sb_addr),
        .WB_sb_data     (WB_sb_data),
        .WB_sb_size     (WB_sb_size),
        .WB_sb_stall    (WB_sb_stall),
        .Dcache_Write   (Dcache_Write),
        .Dcache_Address (Dcache_Address),
        .Dcache_Data    (Dcache_Data),
        .Dcache_Size    (Dcache_Size),
        .In_write_ready (In_write_ready),
        .sb_count       (sb_count),
        .sb_empty       (sb_empty),
        .sb_full        (sb_full),
        .ld_addr        (ld_addr),
        .ld_fwd_hit     (ld_fwd_hit),
        .ld_fwd_data    (ld_fwd_data),
        .ld_conflict    (ld_conflict)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One cycle: inputs applied, then the outputs expected before the edge.
    typedef struct {
        logic        enq;
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
        logic        rdy;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [63:0] e_data;
        logic [1:0]  e_size;
        logic [2:0]  e_cnt;
        logic        e_stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic enq, input logic [31:0] addr,
                               input logic [63:0] data, input logic [1:0] size,
                               input logic rdy, input logic e_wr,
                               input logic [31:0] e_addr, input logic [63:0] e_data,
                               input logic [1:0] e_size, input logic [2:0] e_cnt,
                               input logic e_stall);
        vec_t r;
        r.enq = enq; r.addr = addr; r.data = data; r.size = size; r.rdy = rdy;
        r.e_wr = e_wr; r.e_addr = e_addr; r.e_data = e_data; r.e_size = e_size;
        r.e_cnt = e_cnt; r.e_stall = e_stall;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic enq, input logic [31:0] addr,
                         input logic [63:0] data, input logic [1:0] size, input logic rdy);
        WB_sb_enq_v    = enq;
        WB_sb_addr     = addr;
        WB_sb_data     = data;
        WB_sb_size     = size;
        In_write_ready = rdy;
    endtask

    initial begin
        CLR     = 1'b1;
        ld_addr = 32'h0;
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0);

        // single store: enqueue, present next cycle, gone after acceptance
        vecs.push_back(v(1, 32'h1000, 64'hAA, 2'b10, 1,  0, 32'h0,    64'h0,  2'b00, 3'd0, 0));
        vecs.push_back(v(0, 32'h0,    64'h0,  2'b00, 1,  1, 32'h1000, 64'hAA, 2'b10, 3'd1, 0));
        vecs.push_back(v(0, 32'h0,    64'h0,  2'b00, 0,  0, 32'h0,    64'h0,  2'b00, 3'd0, 0));
        // fill to DEPTH with ready low, then refused and accepted 5th enqueue
        vecs.push_back(v(1, 32'h100, 64'h1, 2'b00, 0,  0, 32'h0,   64'h0, 2'b00, 3'd0, 0));
        vecs.push_back(v(1, 32'h108, 64'h2, 2'b01, 0,  1, 32'h100, 64'h1, 2'b00, 3'd1, 0));
        vecs.push_back(v(1, 32'h110, 64'h3, 2'b10, 0,  1, 32'h100, 64'h1, 2'b00, 3'd2, 0));
        vecs.push_back(v(1, 32'h118, 64'h4, 2'b11, 0,  1, 32'h100, 64'h1, 2'b00, 3'd3, 0));
        vecs.push_back(v(1, 32'h120, 64'h5, 2'b00, 0,  1, 32'h100, 64'h1, 2'b00, 3'd4, 1));
        vecs.push_back(v(1, 32'h120, 64'h5, 2'b00, 1,  1, 32'h100, 64'h1, 2'b00, 3'd4, 0));
        // drain across the pointer wrap with ready toggling; one late enqueue
        vecs.push_back(v(0, 32'h0,   64'h0, 2'b00, 0,  1, 32'h108, 64'h2, 2'b01, 3'd4, 0));
        vecs.push_back(v(0, 32'h0,   64'h0, 2'b00, 1,  1, 32'h108, 64'h2, 2'b01, 3'd4, 0));
        vecs.push_back(v(0, 32'h0,   64'h0, 2'b00, 0,  1, 32'h110, 64'h3, 2'b10, 3'd3, 0));
        vecs.push_back(v(0, 32'h0,   64'h0, 2'b00, 1,  1, 32'h110, 64'h3, 2'b10, 3'd3, 0));
        vecs.push_back(v(1, 32'h128, 64'h6, 2'b01, 0,  1, 32'h118, 64'h4, 2'b11, 3'd2, 0));
        vecs.push_back(v(0, 32'h0,   64'h0, 2'b00, 1,  1, 32'h118, 64'h4, 2'b11, 3'd3, 0));
        vecs.push_back(v(0, 32'h0,   64'h0, 2'b00, 0,  1, 32'h120, 64'h5, 2'b00, 3'd2, 0));
        vecs.push_back(v(0, 32'h0,   64'h0, 2'b00, 1,  1, 32'h120, 64'h5, 2'b00, 3'd2, 0));
        vecs.push_back(v(0, 32'h0,   64'h0, 2'b00, 0,  1, 32'h128, 64'h6, 2'b01, 3'd1, 0));
        vecs.push_back(v(0, 32'h0,   64'h0, 2'b00, 1,  1, 32'h128, 64'h6, 2'b01, 3'd1, 0));
        vecs.push_back(v(0, 32'h0,   64'h0, 2'b00, 0,  0, 32'h0,   64'h0, 2'b00, 3'd0, 0));
        // build count 2, then five cycles of simultaneous enqueue and dequeue
        vecs.push_back(v(1, 32'h200, 64'h10, 2'b10, 1,  0, 32'h0,   64'h0,  2'b00, 3'd0, 0));
        vecs.push_back(v(1, 32'h208, 64'h11, 2'b10, 0,  1, 32'h200, 64'h10, 2'b10, 3'd1, 0));
        vecs.push_back(v(1, 32'h210, 64'h12, 2'b10, 1,  1, 32'h200, 64'h10, 2'b10, 3'd2, 0));
        vecs.push_back(v(1, 32'h218, 64'h13, 2'b10, 1,  1, 32'h208, 64'h11, 2'b10, 3'd2, 0));
        vecs.push_back(v(1, 32'h220, 64'h14, 2'b10, 1,  1, 32'h210, 64'h12, 2'b10, 3'd2, 0));
        vecs.push_back(v(1, 32'h228, 64'h15, 2'b10, 1,  1, 32'h218, 64'h13, 2'b10, 3'd2, 0));
        vecs.push_back(v(1, 32'h230, 64'h16, 2'b10, 1,  1, 32'h220, 64'h14, 2'b10, 3'd2, 0));
        vecs.push_back(v(0, 32'h0,   64'h0,  2'b00, 1,  1, 32'h228, 64'h15, 2'b10, 3'd2, 0));
        vecs.push_back(v(0, 32'h0,   64'h0,  2'b00, 1,  1, 32'h230, 64'h16, 2'b10, 3'd1, 0));
        vecs.push_back(v(0, 32'h0,   64'h0,  2'b00, 0,  0, 32'h0,   64'h0,  2'b00, 3'd0, 0));

        // reset state, with an enqueue request present during reset
        repeat (2) @(negedge CLK);
        drive(1'b1, 32'hDEAD0, 64'h1, 2'b00, 1'b1);
        #1;
        chk("rst_write", 64'(Dcache_Write), 64'd0);
        chk("rst_count", 64'(sb_count), 64'd0);
        chk("rst_empty", 64'(sb_empty), 64'd1);
        chk("rst_full",  64'(sb_full), 64'd0);
        chk("rst_stall", 64'(WB_sb_stall), 64'd0);
        chk("rst_hit",   64'(ld_fwd_hit), 64'd0);
        chk("rst_confl", 64'(ld_conflict), 64'd0);
        @(negedge CLK);
        CLR = 1'b0;
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            drive(vecs[i].enq, vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].rdy);
            #1;
            chk($sformatf("v%0d_count", i), 64'(sb_count), 64'(vecs[i].e_cnt));
            chk($sformatf("v%0d_write", i), 64'(Dcache_Write), 64'(vecs[i].e_wr));
            chk($sformatf("v%0d_stall", i), 64'(WB_sb_stall), 64'(vecs[i].e_stall));
            chk($sformatf("v%0d_full", i),  64'(sb_full),  64'(vecs[i].e_cnt == 3'd4));
            chk($sformatf("v%0d_empty", i), 64'(sb_empty), 64'(vecs[i].e_cnt == 3'd0));
            if (vecs[i].e_wr) begin
                chk($sformatf("v%0d_addr", i), 64'(Dcache_Address), 64'(vecs[i].e_addr));
                chk($sformatf("v%0d_data", i), Dcache_Data, vecs[i].e_data);
                chk($sformatf("v%0d_size", i), 64'(Dcache_Size), 64'(vecs[i].e_size));
            end
        end

        // load probe: two qword stores to 0x2000, younger one must win
        @(negedge CLK);
        drive(1'b1, 32'h2000, 64'h1111, 2'b11, 1'b0);
        @(negedge CLK);
        drive(1'b1, 32'h2000, 64'h2222, 2'b11, 1'b0);
        @(negedge CLK);
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0);
        ld_addr = 32'h2000;
        #1;
        chk("fwd_count", 64'(sb_count), 64'd2);
`ifdef WB_SB_FORWARD_EN
        chk("fwd_hit",   64'(ld_fwd_hit), 64'd1);
        chk("fwd_data",  ld_fwd_data, 64'h2222);
        chk("fwd_confl", 64'(ld_conflict), 64'd0);
        ld_addr = 32'h2004;
        #1;
        chk("part_hit",   64'(ld_fwd_hit), 64'd0);
        chk("part_confl", 64'(ld_conflict), 64'd1);
        ld_addr = 32'h3000;
        #1;
        chk("miss_hit",   64'(ld_fwd_hit), 64'd0);
        chk("miss_confl", 64'(ld_conflict), 64'd0);
        chk("miss_data",  ld_fwd_data, 64'h0);
`else
        chk("off_hit",   64'(ld_fwd_hit), 64'd0);
        chk("off_confl", 64'(ld_conflict), 64'd0);
        chk("off_data",  ld_fwd_data, 64'h0);
`endif

        // third store, then an asynchronous reset pulse between edges
        @(negedge CLK);
        drive(1'b1, 32'h2400, 64'h33, 2'b10, 1'b0);
        @(negedge CLK);
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0);
        #1;
        chk("pre_clr_count", 64'(sb_count), 64'd3);
        #1 CLR = 1'b1;
        #1 CLR = 1'b0;
        #1;
        chk("clr_write", 64'(Dcache_Write), 64'd0);
        chk("clr_count", 64'(sb_count), 64'd0);
        chk("clr_empty", 64'(sb_empty), 64'd1);
        chk("clr_hit",   64'(ld_fwd_hit), 64'd0);
        chk("clr_confl", 64'(ld_conflict), 64'd0);

        // buffer restarts cleanly after reset
        @(negedge CLK);
        drive(1'b1, 32'h500, 64'h55, 2'b00, 1'b0);
        @(negedge CLK);
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0);
        #1;
        chk("post_write", 64'(Dcache_Write), 64'd1);
        chk("post_addr",  64'(Dcache_Address), 64'h500);
        chk("post_data",  Dcache_Data, 64'h55);
        chk("post_size",  64'(Dcache_Size), 64'd0);
        chk("post_count", 64'(sb_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
